// File: rtl/sdram_burst_pkg.sv
// Shared constants and state encoding for the SDRAM ring-buffer burst engine.
package sdram_burst_pkg;

  localparam int DEF_DW        = 16;
  localparam int DEF_AW        = 22;
  localparam int DEF_BURST_LEN = 64;
  localparam int CNT_W         = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_RD    = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } burst_state_e;

  // Beat counters must hold the value BURST_LEN itself, hence the extra bit.
  function automatic int beat_cnt_w(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/sdram_burst_stats.sv
// Completed-burst and rejected-command counters (built only with SDRAM_BURST_STATS_EN).
module sdram_burst_stats
  import sdram_burst_pkg::*;
(
  input  logic             sdram_clk,
  input  logic             reset,
  input  logic             wr_done_i,
  input  logic             rd_done_i,
  input  logic             rej_i,
  output logic [CNT_W-1:0] wr_bursts_o,
  output logic [CNT_W-1:0] rd_bursts_o,
  output logic [CNT_W-1:0] rej_cnt_o
);

  logic [CNT_W-1:0] wr_q, rd_q, rej_q;
  logic [CNT_W-1:0] wr_d, rd_d, rej_d;

  // Counters wrap naturally at 2**CNT_W.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    rej_d = rej_q;
    if (wr_done_i) wr_d = wr_q + CNT_W'(1);
    else           wr_d = wr_q;
    if (rd_done_i) rd_d = rd_q + CNT_W'(1);
    else           rd_d = rd_q;
    if (rej_i)     rej_d = rej_q + CNT_W'(1);
    else           rej_d = rej_q;
  end

  // Counter registers.
  always_ff @(posedge sdram_clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      rej_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      rej_q <= rej_d;
    end
  end

  assign wr_bursts_o = wr_q;
  assign rd_bursts_o = rd_q;
  assign rej_cnt_o   = rej_q;

endmodule

// File: rtl/sdram_burst_engine.sv
// Moves whole bursts between the input/output FIFOs and an SDRAM ring buffer.
// Optional statistics counters are enabled by defining SDRAM_BURST_STATS_EN.
module sdram_burst_engine
  import sdram_burst_pkg::*;
#(
  parameter int DW        = DEF_DW,
  parameter int AW        = DEF_AW,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic          sdram_clk,
  input  logic          reset,
  input  logic          wr_strobe,
  input  logic          rd_strobe,
  output logic          sd_ready,
  input  logic [DW-1:0] in_q,
  input  logic          in_empty,
  output logic          in_rdreq,
  output logic [DW-1:0] out_data,
  output logic          out_wrreq,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW:0]   level,
  output logic          ovf
`ifdef SDRAM_BURST_STATS_EN
  ,
  output logic [CNT_W-1:0] wr_bursts,
  output logic [CNT_W-1:0] rd_bursts,
  output logic [CNT_W-1:0] rej_cnt
`endif
);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_WR    = S_WR;
  localparam logic [2:0] ST_RD    = S_RD;
  localparam logic [2:0] ST_DRAIN = S_DRAIN;
  localparam logic [2:0] ST_DONE  = S_DONE;

  localparam int CW = beat_cnt_w(BURST_LEN);
  localparam logic [CW-1:0] BL_CNT   = CW'(BURST_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);
  localparam logic [AW:0]   BL_LVL   = (AW+1)'(BURST_LEN);
  // Highest fill level that still leaves room for one more burst.
  localparam logic [AW:0]   WR_LIMIT = (AW+1)'((1 << AW) - BURST_LEN);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] ack_cnt_q, ack_cnt_d;
  logic [CW-1:0] rv_cnt_q, rv_cnt_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] out_data_q;
  logic          out_wrreq_q;

  logic          mem_req_s;
  logic          mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic          rv_take_s;
  logic          wr_done_s;
  logic          rd_done_s;
  logic          rej_s;

  // Read beats are accepted only while a read burst is outstanding.
  assign rv_take_s = mem_rvalid && ((state_q == ST_RD) || (state_q == ST_DRAIN))
                     && (rv_cnt_q != BL_CNT);

  // Burst sequencing, pointer and fill-level bookkeeping.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ack_cnt_d  = ack_cnt_q;
    rv_cnt_d   = rv_take_s ? (rv_cnt_q + CW'(1)) : rv_cnt_q;
    level_d    = level_q;
    ovf_d      = ovf_q;
    mem_req_s  = 1'b0;
    mem_we_s   = 1'b0;
    mem_addr_s = '0;
    wr_done_s  = 1'b0;
    rd_done_s  = 1'b0;
    rej_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_strobe) begin
          if (level_q <= WR_LIMIT) begin
            state_d   = ST_WR;
            ack_cnt_d = '0;
          end else begin
            ovf_d   = 1'b1;
            rej_s   = 1'b1;
            state_d = ST_DONE;
          end
        end else if (rd_strobe) begin
          if (level_q >= BL_LVL) begin
            state_d   = ST_RD;
            ack_cnt_d = '0;
            rv_cnt_d  = '0;
          end else begin
            rej_s   = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        // An empty input FIFO simply stalls the request.
        mem_req_s  = !in_empty;
        mem_we_s   = 1'b1;
        mem_addr_s = wptr_q;
        if (mem_req_s && mem_ack) begin
          wptr_d    = wptr_q + AW'(1);
          ack_cnt_d = ack_cnt_q + CW'(1);
          if (ack_cnt_q == LAST_CNT) begin
            level_d   = level_q + BL_LVL;
            wr_done_s = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_WR;
          end
        end else begin
          state_d = ST_WR;
        end
      end
      ST_RD: begin
        mem_req_s  = 1'b1;
        mem_addr_s = rptr_q;
        if (mem_ack) begin
          rptr_d    = rptr_q + AW'(1);
          ack_cnt_d = ack_cnt_q + CW'(1);
          if (ack_cnt_q == LAST_CNT) state_d = ST_DRAIN;
          else                       state_d = ST_RD;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_DRAIN: begin
        if (rv_cnt_d == BL_CNT) begin
          level_d   = level_q - BL_LVL;
          rd_done_s = 1'b1;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Engine state registers; reset discards any stored ring contents.
  always_ff @(posedge sdram_clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      ack_cnt_q   <= '0;
      rv_cnt_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_wrreq_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ack_cnt_q   <= ack_cnt_d;
      rv_cnt_q    <= rv_cnt_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
      out_data_q  <= rv_take_s ? mem_rdata : out_data_q;
      out_wrreq_q <= rv_take_s;
    end
  end

  assign sd_ready  = (state_q == ST_IDLE);
  assign mem_req   = mem_req_s;
  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_addr_s;
  assign mem_wdata = in_q;
  assign in_rdreq  = mem_req_s & mem_we_s & mem_ack;
  assign out_data  = out_data_q;
  assign out_wrreq = out_wrreq_q;
  assign level     = level_q;
  assign ovf       = ovf_q;

`ifdef SDRAM_BURST_STATS_EN
  sdram_burst_stats u_stats (
    .sdram_clk   (sdram_clk),
    .reset       (reset),
    .wr_done_i   (wr_done_s),
    .rd_done_i   (rd_done_s),
    .rej_i       (rej_s),
    .wr_bursts_o (wr_bursts),
    .rd_bursts_o (rd_bursts),
    .rej_cnt_o   (rej_cnt)
  );
`else
  logic stats_unused_s;
  assign stats_unused_s = ^{wr_done_s, rd_done_s, rej_s};
`endif

endmodule

// File: tb/tb_sdram_burst_engine.sv
// Randomized scoreboard bench for sdram_burst_engine (AW=8 so the ring can be filled).
module tb_sdram_burst_engine;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int BL    = 64;
  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic          sdram_clk = 1'b0;
  logic          reset     = 1'b0;
  logic          wr_strobe = 1'b0;
  logic          rd_strobe = 1'b0;
  logic          sd_ready;
  logic [DW-1:0] in_q      = '0;
  logic          in_empty  = 1'b1;
  logic          in_rdreq;
  logic [DW-1:0] out_data;
  logic          out_wrreq;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack    = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata  = '0;
  logic [AW:0]   level;
  logic          ovf;
`ifdef SDRAM_BURST_STATS_EN
  logic [15:0]   wr_bursts, rd_bursts, rej_cnt;
`endif

  sdram_burst_engine #(.DW(DW), .AW(AW), .BURST_LEN(BL)) dut (
    .sdram_clk (sdram_clk),
    .reset     (reset),
    .wr_strobe (wr_strobe),
    .rd_strobe (rd_strobe),
    .sd_ready  (sd_ready),
    .in_q      (in_q),
    .in_empty  (in_empty),
    .in_rdreq  (in_rdreq),
    .out_data  (out_data),
    .out_wrreq (out_wrreq),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .level     (level),
    .ovf       (ovf)
`ifdef SDRAM_BURST_STATS_EN
    ,
    .wr_bursts (wr_bursts),
    .rd_bursts (rd_bursts),
    .rej_cnt   (rej_cnt)
`endif
  );

  always #5 sdram_clk = ~sdram_clk;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { int due; logic [DW-1:0] d; } rd_t;

  int total = 0;
  int bad   = 0;

  // Reference model: ring contents as a plain queue plus level/pointers.
  logic [DW-1:0] fifo[$];
  logic [DW-1:0] ring_ref[$];
  logic [DW-1:0] exp_out[$];
  wr_t           exp_wr[$];
  logic [AW-1:0] exp_raddr[$];
  rd_t           pipe[$];
  logic [DW-1:0] mem_model [0:DEPTH-1];
  int  lvl_ref = 0, wp_ref = 0, rp_ref = 0;
  bit  ovf_ref = 1'b0;
  bit  ack_rand = 1'b0, gap_rand = 1'b0;
  int  cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SDRAM sequencer and input FIFO behaviour.
  initial begin
    forever begin
      @(negedge sdram_clk);
      cyc++;
      if (!reset) begin
        pipe.delete();
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
      end else begin
        mem_ack  = ack_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_empty = (fifo.size() == 0) || (gap_rand && ($urandom_range(0, 4) == 0));
        in_q     = (fifo.size() != 0) ? fifo[0] : 16'h0000;
        if (pipe.size() != 0 && pipe[0].due == cyc) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pipe[0].d;
          void'(pipe.pop_front());
        end else begin
          mem_rvalid = 1'b0;
          mem_rdata  = 16'($urandom);
        end
        #1;
        if (mem_req && mem_ack) begin
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            if (in_rdreq && fifo.size() != 0) void'(fifo.pop_front());
          end else begin
            rd_t e;
            e.due = cyc + LAT;
            e.d   = mem_model[mem_addr];
            pipe.push_back(e);
          end
        end
      end
    end
  end

  // Monitor: compare every DUT transaction against the expected queues.
  initial begin
    forever begin
      @(negedge sdram_clk);
      #2;
      if (reset) begin
        if (out_wrreq) begin
          if (exp_out.size() == 0) check("out_spurious", {31'd0, out_wrreq}, 32'd0);
          else check("out_data", {16'd0, out_data}, {16'd0, exp_out.pop_front()});
        end
        if (mem_req && mem_ack && mem_we) begin
          if (exp_wr.size() == 0) check("wr_spurious", {31'd0, mem_req}, 32'd0);
          else begin
            wr_t e;
            e = exp_wr.pop_front();
            check("wr_addr", {24'd0, mem_addr}, {24'd0, e.a});
            check("wr_data", {16'd0, mem_wdata}, {16'd0, e.d});
            check("in_rdreq", {31'd0, in_rdreq}, 32'd1);
          end
        end
        if (mem_req && mem_ack && !mem_we) begin
          if (exp_raddr.size() == 0) check("rd_spurious", {31'd0, mem_req}, 32'd0);
          else check("rd_addr", {24'd0, mem_addr}, {24'd0, exp_raddr.pop_front()});
        end
      end
    end
  end

  task automatic cmd(input bit wr, input bit rd, input bit seq, input bit stray,
                     input bit directed, input bit wait_done);
    int low;
    bit acc;
    acc = 1'b0;
    @(negedge sdram_clk);
    #3;
    check("ready_before", {31'd0, sd_ready}, 32'd1);
    if (wr) begin
      if (lvl_ref <= DEPTH - BL) begin
        acc = 1'b1;
        for (int i = 0; i < BL; i++) begin
          wr_t e;
          logic [DW-1:0] w;
          w = seq ? DW'(i) : DW'($urandom);
          fifo.push_back(w);
          ring_ref.push_back(w);
          e.a = AW'((wp_ref + i) % DEPTH);
          e.d = w;
          exp_wr.push_back(e);
        end
        wp_ref  = (wp_ref + BL) % DEPTH;
        lvl_ref = lvl_ref + BL;
      end else begin
        ovf_ref = 1'b1;
      end
    end else if (rd) begin
      if (lvl_ref >= BL) begin
        acc = 1'b1;
        for (int i = 0; i < BL; i++) begin
          exp_raddr.push_back(AW'((rp_ref + i) % DEPTH));
          exp_out.push_back(ring_ref.pop_front());
        end
        rp_ref  = (rp_ref + BL) % DEPTH;
        lvl_ref = lvl_ref - BL;
      end
    end
    wr_strobe = wr;
    rd_strobe = rd;
    @(negedge sdram_clk);
    wr_strobe = 1'b0;
    rd_strobe = 1'b0;
    #3;
    check("ready_drop", {31'd0, sd_ready}, 32'd0);
    if (directed) check("req_next", {31'd0, mem_req}, {31'd0, acc});
    if (wait_done) begin
      low = 0;
      while (!sd_ready && low < 2000) begin
        low++;
        rd_strobe = stray && (low == 5);
        @(negedge sdram_clk);
        rd_strobe = 1'b0;
        #3;
      end
      if (!sd_ready) begin
        check("done_timeout", {31'd0, sd_ready}, 32'd1);
      end else begin
        check("level", {23'd0, level}, 32'(lvl_ref));
        check("ovf", {31'd0, ovf}, {31'd0, ovf_ref});
        check("wr_left", 32'(exp_wr.size()), 32'd0);
        check("out_left", 32'(exp_out.size()), 32'd0);
        if (directed && !acc) check("low_rej", 32'(low), 32'd1);
        if (directed && acc && wr) check("low_wr", 32'(low), 32'(BL + 1));
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge sdram_clk);
    #3;
    check("rst_ready", {31'd0, sd_ready}, 32'd1);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_level", {23'd0, level}, 32'd0);
    check("rst_out", {15'd0, out_wrreq, out_data}, 32'd0);
    @(negedge sdram_clk);
    reset = 1'b1;

    // Directed: sequential write, read back, empty read, fill/overflow, wrap.
    cmd(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Randomized: ack stalls, FIFO gaps, mixed and simultaneous strobes.
    ack_rand = 1'b1;
    gap_rand = 1'b1;
    cmd(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      int op;
      op = $urandom_range(0, 2);
      cmd(op != 1, op != 0, 1'b0, k[0], 1'b0, 1'b1);
    end

    // Reset in the middle of a read burst.
    if (lvl_ref < BL) cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge sdram_clk);
    reset = 1'b0;
    fifo.delete();
    ring_ref.delete();
    exp_out.delete();
    exp_wr.delete();
    exp_raddr.delete();
    lvl_ref = 0;
    wp_ref  = 0;
    rp_ref  = 0;
    ovf_ref = 1'b0;
    @(negedge sdram_clk);
    #3;
    check("mid_rst_ready", {31'd0, sd_ready}, 32'd1);
    check("mid_rst_mem", {30'd0, mem_req, mem_we}, 32'd0);
    check("mid_rst_addr", {24'd0, mem_addr}, 32'd0);
    check("mid_rst_out", {15'd0, out_wrreq, out_data}, 32'd0);
    check("mid_rst_rdreq", {31'd0, in_rdreq}, 32'd0);
    check("mid_rst_level", {23'd0, level}, 32'd0);
    check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge sdram_clk);
    reset = 1'b1;

    cmd(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    repeat (5) @(negedge sdram_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
